// File: rtl/rf_write_arbiter.sv
// rf_write_arbiter: shares the register-file write port between pipeline WB and a buffered long-latency unit
module rf_write_arbiter #(
    parameter int DEPTH        = 4,
    parameter int STARVE_LIMIT = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wb_valid,
    input  logic [4:0]  wb_addr,
    input  logic [31:0] wb_data,
    input  logic        lu_valid,
    output logic        lu_ready,
    input  logic [4:0]  lu_addr,
    input  logic [31:0] lu_data,
    input  logic [4:0]  id_rs1_addr,
    input  logic [4:0]  id_rs2_addr,
    input  logic [4:0]  id_rd_addr,
    output logic        rf_we,
    output logic [4:0]  rf_waddr,
    output logic [31:0] rf_wdata,
    output logic        pend_hazard,
    output logic        stall_req,
    output logic        collision_err
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int SW = $clog2(STARVE_LIMIT + 1);

    logic [4:0]       addr_q [DEPTH];
    logic [31:0]      data_q [DEPTH];
    logic [DEPTH-1:0] vld;
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic [CW-1:0]    count;
    logic [SW-1:0]    starve;
    logic             full, empty, wb_wr, push, pop, buf_hit, wb_hit;

    function automatic logic id_match(input logic [4:0] a);
        return a != '0 && (a == id_rs1_addr || a == id_rs2_addr || a == id_rd_addr);
    endfunction

    always_comb begin
        full        = count == CW'(DEPTH);
        empty       = count == '0;
        lu_ready    = !rst && !full;
        push        = lu_valid && lu_ready && lu_addr != '0;
        wb_wr       = !rst && wb_valid && wb_addr != '0;
        pop         = !rst && !wb_wr && !empty;
        rf_we       = wb_wr || pop;
        rf_waddr    = wb_wr ? wb_addr : pop ? addr_q[rd_ptr] : '0;
        rf_wdata    = wb_wr ? wb_data : pop ? data_q[rd_ptr] : '0;
        stall_req   = !rst && (starve == SW'(STARVE_LIMIT) || full);
    end

    // Entries are tracked by a valid bit so hazard/collision compares need no pointer arithmetic
    always_comb begin
        buf_hit = 1'b0;
        wb_hit  = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            buf_hit = buf_hit || (vld[i] && id_match(addr_q[i]));
            wb_hit  = wb_hit || (vld[i] && addr_q[i] == wb_addr);
        end
        pend_hazard = !rst && (buf_hit || (push && id_match(lu_addr)));
    end

    always_ff @(posedge clk) begin
        if (push) begin
            addr_q[wr_ptr] <= lu_addr;
            data_q[wr_ptr] <= lu_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld           <= '0;
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            count         <= '0;
            starve        <= '0;
            collision_err <= 1'b0;
        end else begin
            if (push) begin
                vld[wr_ptr] <= 1'b1;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) begin
                vld[rd_ptr] <= 1'b0;
                rd_ptr      <= rd_ptr + 1'b1;
            end
            count         <= count + CW'(push) - CW'(pop);
            starve        <= (pop || empty) ? '0 : (starve == SW'(STARVE_LIMIT)) ? starve : starve + 1'b1;
            collision_err <= collision_err || (wb_wr && wb_hit);
        end
    end
endmodule

// File: tb/tb_rf_write_arbiter.sv
// tb_rf_write_arbiter: directed scenario tasks plus a queue-based reference monitor
module tb_rf_write_arbiter;
    localparam int DEPTH = 4;
    localparam int STARVE_LIMIT = 8;

    logic clk = 0, rst = 1;
    logic wb_valid = 0, lu_valid = 0;
    logic [4:0] wb_addr = 0, lu_addr = 0, id_rs1_addr = 0, id_rs2_addr = 0, id_rd_addr = 0;
    logic [31:0] wb_data = 0, lu_data = 0;
    logic lu_ready, rf_we, pend_hazard, stall_req, collision_err;
    logic [4:0] rf_waddr;
    logic [31:0] rf_wdata;
    int n_checks = 0, n_fail = 0;
    bit mon_en = 0;

    typedef struct packed { logic [4:0] addr; logic [31:0] data; } ent_t;
    ent_t m_q[$];
    int m_starve = 0;
    bit m_coll = 0;

    rf_write_arbiter #(.DEPTH(DEPTH), .STARVE_LIMIT(STARVE_LIMIT)) dut (
        .clk(clk), .rst(rst), .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data),
        .lu_valid(lu_valid), .lu_ready(lu_ready), .lu_addr(lu_addr), .lu_data(lu_data),
        .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr), .id_rd_addr(id_rd_addr),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .pend_hazard(pend_hazard),
        .stall_req(stall_req), .collision_err(collision_err)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    function automatic bit hit(input logic [4:0] a);
        return a != 0 && (a == id_rs1_addr || a == id_rs2_addr || a == id_rd_addr);
    endfunction

    always @(negedge clk) begin : monitor
        bit e_ready, wbw, mpop, mpush, e_we, hz, e_stall, whit;
        logic [4:0] e_addr;
        logic [31:0] e_data;
        if (mon_en) begin
            e_ready = !rst && m_q.size() < DEPTH;
            wbw = !rst && wb_valid && wb_addr != 0;
            mpop = !rst && !wbw && m_q.size() > 0;
            mpush = lu_valid && e_ready && lu_addr != 0;
            e_we = wbw || mpop;
            e_addr = wbw ? wb_addr : mpop ? m_q[0].addr : 5'd0;
            e_data = wbw ? wb_data : mpop ? m_q[0].data : 32'd0;
            hz = mpush && hit(lu_addr);
            whit = 0;
            foreach (m_q[i]) begin
                if (hit(m_q[i].addr)) hz = 1;
                if (m_q[i].addr == wb_addr) whit = 1;
            end
            hz = hz && !rst;
            e_stall = !rst && (m_starve == STARVE_LIMIT || m_q.size() == DEPTH);
            n_checks++;
            if ({rf_we, rf_waddr, rf_wdata} !== {e_we, e_addr, e_data}) begin
                n_fail++;
                $display("FAIL mon_port t=%0t: got we=%0b a=%0d d=%h, expected we=%0b a=%0d d=%h",
                         $time, rf_we, rf_waddr, rf_wdata, e_we, e_addr, e_data);
            end
            n_checks++;
            if ({lu_ready, stall_req, pend_hazard, collision_err} !== {e_ready, e_stall, hz, m_coll}) begin
                n_fail++;
                $display("FAIL mon_flags t=%0t: got rdy/stall/haz/coll=%b, expected %b",
                         $time, {lu_ready, stall_req, pend_hazard, collision_err}, {e_ready, e_stall, hz, m_coll});
            end
            if (rst) begin
                m_q.delete();
                m_starve = 0;
                m_coll = 0;
            end else begin
                if (wbw && whit) m_coll = 1;
                m_starve = (mpop || m_q.size() == 0) ? 0 : (m_starve < STARVE_LIMIT ? m_starve + 1 : m_starve);
                if (mpop) void'(m_q.pop_front());
                if (mpush) m_q.push_back('{lu_addr, lu_data});
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        step();
        wb_valid = 0; lu_valid = 0; lu_addr = 0; wb_addr = 0;
        id_rs1_addr = 0; id_rs2_addr = 0; id_rd_addr = 0;
    endtask

    task automatic test_reset();
        wb_valid = 1; wb_addr = 3; lu_valid = 1; lu_addr = 4; id_rs1_addr = 4;
        @(posedge clk);
        @(posedge clk);
        #1 mon_en = 1;
        @(negedge clk);
        n_checks++;
        if ({rf_we, lu_ready, stall_req, pend_hazard, collision_err} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: got we/rdy/stall/haz/coll=%b, expected 00000",
                     {rf_we, lu_ready, stall_req, pend_hazard, collision_err});
        end
        step();
        rst = 0; wb_valid = 0; lu_valid = 0; id_rs1_addr = 0;
        @(negedge clk);
        n_checks++;
        if (lu_ready !== 1'b1 || rf_we !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release: got lu_ready=%0b rf_we=%0b, expected 1 0", lu_ready, rf_we);
        end
    endtask

    task automatic test_single();
        step();
        lu_valid = 1; lu_addr = 5; lu_data = 32'hDEADBEEF;
        @(negedge clk);
        n_checks++;
        if (rf_we !== 1'b0) begin n_fail++; $display("FAIL single_latency: rf_we=%0b expected 0", rf_we); end
        step();
        lu_valid = 0;
        @(negedge clk);
        n_checks++;
        if ({rf_we, rf_waddr, rf_wdata} !== {1'b1, 5'd5, 32'hDEADBEEF}) begin
            n_fail++;
            $display("FAIL single_commit: got we=%0b a=%0d d=%h, expected 1 5 deadbeef", rf_we, rf_waddr, rf_wdata);
        end
        step();
        @(negedge clk);
        n_checks++;
        if (rf_we !== 1'b0) begin n_fail++; $display("FAIL single_empty: rf_we=%0b expected 0", rf_we); end
    endtask

    task automatic test_full_order();
        for (int i = 0; i < 4; i++) begin
            step();
            wb_valid = 1; wb_addr = 3; wb_data = 32'(i); lu_valid = 1; lu_addr = 5'(10 + i); lu_data = 32'h1000 + 32'(i);
        end
        step();
        lu_addr = 20;
        @(negedge clk);
        n_checks++;
        if ({lu_ready, stall_req, rf_waddr} !== {1'b0, 1'b1, 5'd3}) begin
            n_fail++;
            $display("FAIL full_flags: got rdy=%0b stall=%0b a=%0d, expected 0 1 3", lu_ready, stall_req, rf_waddr);
        end
        for (int i = 0; i < 4; i++) begin
            step();
            wb_valid = 0; lu_valid = 0;
            @(negedge clk);
            n_checks++;
            if ({rf_we, rf_waddr, rf_wdata} !== {1'b1, 5'(10 + i), 32'h1000 + 32'(i)}) begin
                n_fail++;
                $display("FAIL full_order[%0d]: got we=%0b a=%0d d=%h, expected a=%0d", i, rf_we, rf_waddr, rf_wdata, 10 + i);
            end
        end
        step();
        @(negedge clk);
        n_checks++;
        if (rf_we !== 1'b0) begin n_fail++; $display("FAIL full_drained: rf_we=%0b expected 0", rf_we); end
    endtask

    task automatic test_starve();
        step();
        wb_valid = 1; wb_addr = 3; lu_valid = 1; lu_addr = 7; lu_data = 32'h77;
        for (int i = 0; i < 8; i++) begin
            step();
            lu_valid = 0;
            @(negedge clk);
            n_checks++;
            if (stall_req !== 1'b0) begin n_fail++; $display("FAIL starve_early[%0d]: stall_req=%0b expected 0", i, stall_req); end
        end
        step();
        @(negedge clk);
        n_checks++;
        if (stall_req !== 1'b1) begin n_fail++; $display("FAIL starve_rise: stall_req=%0b expected 1", stall_req); end
        step();
        wb_valid = 0;
        @(negedge clk);
        n_checks++;
        if ({stall_req, rf_we, rf_waddr} !== {1'b1, 1'b1, 5'd7}) begin
            n_fail++;
            $display("FAIL starve_pop: got stall=%0b we=%0b a=%0d, expected 1 1 7", stall_req, rf_we, rf_waddr);
        end
        step();
        @(negedge clk);
        n_checks++;
        if (stall_req !== 1'b0) begin n_fail++; $display("FAIL starve_drop: stall_req=%0b expected 0", stall_req); end
    endtask

    task automatic test_hazard();
        step();
        wb_valid = 1; wb_addr = 3; lu_valid = 1; lu_addr = 7; lu_data = 32'h70;
        step();
        lu_valid = 0; id_rs2_addr = 7;
        @(negedge clk);
        n_checks++;
        if (pend_hazard !== 1'b1) begin n_fail++; $display("FAIL hazard_buf: pend_hazard=%0b expected 1", pend_hazard); end
        step();
        id_rs2_addr = 0; id_rs1_addr = 0; lu_valid = 1; lu_addr = 0;
        @(negedge clk);
        n_checks++;
        if (pend_hazard !== 1'b0) begin n_fail++; $display("FAIL hazard_zero: pend_hazard=%0b expected 0", pend_hazard); end
        step();
        lu_valid = 0; wb_valid = 0;
        @(negedge clk);
        n_checks++;
        if ({rf_we, rf_waddr} !== {1'b1, 5'd7}) begin n_fail++; $display("FAIL hazard_pop: we=%0b a=%0d expected 1 7", rf_we, rf_waddr); end
        step();
        id_rd_addr = 12; lu_valid = 1; lu_addr = 12;
        @(negedge clk);
        n_checks++;
        if ({rf_we, pend_hazard} !== 2'b01) begin
            n_fail++;
            $display("FAIL hazard_inflight: we=%0b haz=%0b expected 0 1", rf_we, pend_hazard);
        end
        idle();
        idle();
    endtask

    task automatic test_collision();
        step();
        wb_valid = 1; wb_addr = 3; lu_valid = 1; lu_addr = 9; lu_data = 32'h99;
        step();
        lu_valid = 0; wb_addr = 9; wb_data = 32'h900D;
        @(negedge clk);
        n_checks++;
        if ({rf_waddr, rf_wdata} !== {5'd9, 32'h900D}) begin
            n_fail++;
            $display("FAIL coll_wb: got a=%0d d=%h expected 9 900d", rf_waddr, rf_wdata);
        end
        for (int i = 0; i < 4; i++) begin
            step();
            wb_valid = 0;
            @(negedge clk);
            n_checks++;
            if (collision_err !== 1'b1) begin n_fail++; $display("FAIL coll_sticky[%0d]: collision_err=%0b expected 1", i, collision_err); end
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 6; i++) begin
            step();
            lu_valid = 1; lu_addr = 5'(16 + i); lu_data = 32'hB0 + 32'(i);
            @(negedge clk);
            n_checks++;
            if (lu_ready !== 1'b1 || (i > 0 && rf_waddr !== 5'(15 + i))) begin
                n_fail++;
                $display("FAIL b2b[%0d]: rdy=%0b a=%0d expected 1 %0d", i, lu_ready, rf_waddr, 15 + i);
            end
        end
        idle();
        @(negedge clk);
        n_checks++;
        if (rf_waddr !== 5'd21) begin n_fail++; $display("FAIL b2b_last: a=%0d expected 21", rf_waddr); end
        idle();
    endtask

    task automatic test_full_pop_reset();
        for (int i = 0; i < 4; i++) begin
            step();
            wb_valid = 1; wb_addr = 3; lu_valid = 1; lu_addr = 5'(11 + i); lu_data = 32'(i);
        end
        step();
        wb_valid = 0; lu_addr = 25;
        @(negedge clk);
        n_checks++;
        if ({lu_ready, rf_we, rf_waddr} !== {1'b0, 1'b1, 5'd11}) begin
            n_fail++;
            $display("FAIL fullpop: got rdy=%0b we=%0b a=%0d expected 0 1 11", lu_ready, rf_we, rf_waddr);
        end
        step();
        @(negedge clk);
        n_checks++;
        if ({lu_ready, rf_waddr} !== {1'b1, 5'd12}) begin
            n_fail++;
            $display("FAIL fullpop_next: got rdy=%0b a=%0d expected 1 12", lu_ready, rf_waddr);
        end
        step();
        wb_valid = 1; lu_valid = 0;
        step();
        rst = 1; id_rs1_addr = 25;
        @(negedge clk);
        n_checks++;
        if ({rf_we, pend_hazard, stall_req} !== 3'b0) begin
            n_fail++;
            $display("FAIL rst_mid: got we/haz/stall=%b expected 000", {rf_we, pend_hazard, stall_req});
        end
        step();
        @(negedge clk);
        n_checks++;
        if (collision_err !== 1'b0) begin n_fail++; $display("FAIL rst_coll: collision_err=%0b expected 0", collision_err); end
        step();
        rst = 0; wb_valid = 0; id_rs1_addr = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            n_checks++;
            if (rf_we !== 1'b0) begin n_fail++; $display("FAIL rst_discard[%0d]: rf_we=%0b expected 0", i, rf_we); end
            step();
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            step();
            rst = $urandom_range(0, 59) == 0;
            wb_valid = $urandom_range(0, 2) == 0;
            wb_addr = 5'($urandom_range(0, 7));
            wb_data = $urandom;
            lu_valid = $urandom_range(0, 1) == 1;
            lu_addr = 5'($urandom_range(0, 7));
            lu_data = $urandom;
            id_rs1_addr = 5'($urandom_range(0, 7));
            id_rs2_addr = 5'($urandom_range(0, 7));
            id_rd_addr = 5'($urandom_range(0, 7));
        end
        rst = 0;
        idle();
    endtask

    initial begin
        test_reset();
        test_single();
        test_full_order();
        test_starve();
        test_hazard();
        test_collision();
        test_back_to_back();
        test_full_pop_reset();
        test_random();
        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/rf_write_arbiter.md
RF_WRITE_ARBITER -- requirements
Module: rf_write_arbiter

Interface
REQ-001 Parameter DEPTH, default 4 (power of two, >=2): entries in the long-latency write buffer.
REQ-002 Parameter STARVE_LIMIT, default 8: head-of-buffer wait cycles before stall_req asserts.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 wb_valid  in  1  pipeline WB stage has a register write this cycle.
REQ-006 wb_addr, wb_data  in  5, 32  pipeline WB destination and data.
REQ-007 lu_valid  in  1  long-latency unit (mul/div, load refill) offers a result.
REQ-008 lu_ready  out  1  arbiter accepts the lu result this cycle.
REQ-009 lu_addr, lu_data  in  5, 32  long-latency destination and data.
REQ-010 id_rs1_addr, id_rs2_addr, id_rd_addr  in  5 each  decode-stage register fields.
REQ-011 rf_we, rf_waddr, rf_wdata  out  1, 5, 32  register-file write port.
REQ-012 pend_hazard  out  1  decode operand/destination matches a buffered write.
REQ-013 stall_req  out  1  requests a pipeline bubble so the buffer can drain.
REQ-014 collision_err  out  1  sticky: WB wrote a register that had a buffered write pending.

Function
REQ-015 Shall hold a DEPTH-entry FIFO of {addr, data}; lu_ready = !full (combinational, no same-cycle pass-through when full).
REQ-016 Transfer on lu_valid && lu_ready; lu_addr==0 is accepted and dropped (not enqueued).
REQ-017 Write port priority: pipeline WB first; wb_valid with wb_addr!=0 drives rf_we=1, rf_waddr=wb_addr, rf_wdata=wb_data.
REQ-018 A WB slot is free when wb_valid==0 or wb_addr==0; on a free slot with FIFO non-empty, the head drives the port and is popped that cycle.
REQ-019 Free slot, FIFO empty: rf_we=0, rf_waddr=0, rf_wdata=0.
REQ-020 Port mux is combinational; an accepted lu result reaches rf_we no earlier than the cycle after acceptance (latency >=1).
REQ-021 Push and pop in the same cycle shall both occur; occupancy unchanged; pointers wrap modulo DEPTH.
REQ-022 Occupancy counter width clog2(DEPTH)+1; full = (count==DEPTH), empty = (count==0).
REQ-023 Starvation counter: cleared on pop or when empty; incremented (saturating at STARVE_LIMIT) each cycle head is non-empty and not popped.
REQ-024 stall_req = (counter==STARVE_LIMIT) || full; deasserts the cycle after the pop that clears the condition.
REQ-025 pend_hazard = 1 when any valid entry addr equals a nonzero id_rs1_addr, id_rs2_addr or id_rd_addr, or when an accepting lu transfer's nonzero lu_addr equals any of them; combinational.
REQ-026 collision_err sets when wb_valid, wb_addr!=0 and wb_addr matches any valid entry; the WB write still proceeds; cleared only by rst.
REQ-027 Entry order preserved: buffered writes commit strictly in acceptance order.

Reset
REQ-028 While rst is high: rf_we=0, lu_ready=0, stall_req=0, pend_hazard=0; FIFO pointers, count and starvation counter cleared; collision_err=0.
REQ-029 Reset mid-operation discards all buffered entries; no write of a discarded entry occurs after rst deasserts.
REQ-030 First cycle after rst deasserts: lu_ready=1, FIFO empty.

Verification
REQ-031 lu x5=0xDEAD_BEEF accepted at cycle 0, wb idle -> cycle 1 rf_we=1, rf_waddr=5, rf_wdata=0xDEADBEEF; FIFO empty cycle 2.
REQ-032 wb_valid=1 continuously (addr 3), 4 lu pushes -> lu_ready=0 after 4th, stall_req=1; first wb bubble commits entries in push order.
REQ-033 Head pending with wb busy for 8 cycles -> stall_req rises at cycle 8; drops the cycle after the pop.
REQ-034 Entry x7 buffered, id_rs2_addr=7 -> pend_hazard=1; id_rs1_addr=0, lu_addr=0 pushed -> pend_hazard=0, nothing enqueued.
REQ-035 Entry x9 buffered, wb_valid with wb_addr=9 -> rf_waddr=9 from WB, collision_err=1 and stays set until rst.
REQ-036 Full FIFO with simultaneous free slot and lu_valid -> pop occurs, lu_ready=0 that cycle; rst asserted with 3 entries -> rf_we=0 and no buffered write ever appears afterwards.
